// File: rtl/lut_sram_arbiter.sv
// Lookup-table SRAM port arbiter: exclusive table load after reset, then
// round-robin reads from two DDS readers; a reload request drains in-flight
// reads and returns to load mode.
module lut_sram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    input  logic          ld_done,
    input  logic          reload,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_gnt,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_valid,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_gnt,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_valid,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_dout,
    output logic          table_ready
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t        state_q;
    logic          rr_q;        // 0: r0 has priority on a tie, 1: r1 has priority
    logic          drain_q;     // set after the first DRAIN cycle
    logic          ready_q;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    vld_pipe_q;  // [0]: address issued, [1]: SRAM sampled it
    logic [1:0]    id_pipe_q;   // reader id riding along with vld_pipe_q
    logic          r0_valid_q, r1_valid_q;
    logic [DW-1:0] r0_rdata_q, r1_rdata_q;
    logic          rd_gnt;

    // Grant decode: state selects who may use the port; reload beats reads
    always_comb begin
        ld_gnt = 1'b0;
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst) begin
            case (state_q)
                S_LOAD: ld_gnt = ld_req;
                S_RUN: begin
                    if (!reload) begin
                        if (r0_req && r1_req) begin
                            r0_gnt = ~rr_q;
                            r1_gnt = rr_q;
                        end else begin
                            r0_gnt = r0_req;
                            r1_gnt = r1_req;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_gnt = r0_gnt | r1_gnt;

    // Table lifetime sequencing and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            rr_q    <= 1'b0;
            drain_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (ld_done) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state_q <= S_DRAIN;
                        ready_q <= 1'b0;
                        drain_q <= 1'b0;
                    end else if (rd_gnt) begin
                        rr_q <= r0_gnt;
                    end
                end
                S_DRAIN: begin
                    // Two cycles are enough for the 2-deep read pipeline to empty
                    if (drain_q) state_q <= S_LOAD;
                    else         drain_q <= 1'b1;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // SRAM port registers: writes only come from LOAD, reads only from RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= ld_gnt;
            if (ld_gnt) begin
                addr_q  <= ld_addr;
                wdata_q <= ld_wdata;
            end else if (r0_gnt) begin
                addr_q  <= r0_addr;
            end else if (r1_gnt) begin
                addr_q  <= r1_addr;
            end
        end
    end

    // Read return pipeline: SRAM samples one edge after issue, data captured the next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
            r0_valid_q <= 1'b0;
            r1_valid_q <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_gnt};
            id_pipe_q  <= {id_pipe_q[0], r1_gnt};
            r0_valid_q <= vld_pipe_q[1] & ~id_pipe_q[1];
            r1_valid_q <= vld_pipe_q[1] &  id_pipe_q[1];
            if (vld_pipe_q[1] && !id_pipe_q[1]) r0_rdata_q <= sram_dout;
            if (vld_pipe_q[1] &&  id_pipe_q[1]) r1_rdata_q <= sram_dout;
        end
    end

    assign sram_wen    = wen_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign table_ready = ready_q;
    assign r0_valid    = r0_valid_q;
    assign r1_valid    = r1_valid_q;
    assign r0_rdata    = r0_rdata_q;
    assign r1_rdata    = r1_rdata_q;

endmodule
